// File: rtl/rtc_seg_monitor.sv
// Receive-side checker for the RTC 7-segment digit buses: decodes BCD time,
// validates codes, range and +1 s stepping, and counts error cycles.
//
// state | meaning
// SYNC  | waiting for a legal, in-range sample to load the reference time
// TRACK | locked; every change must be exactly +1 s from the reference
module rtc_seg_monitor #(
    parameter bit H12     = 1'b0,
    parameter int MAX_GAP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  sl,
    input  logic [6:0]  sm,
    input  logic [6:0]  ml,
    input  logic [6:0]  mm,
    input  logic [6:0]  hl,
    input  logic [6:0]  hm,
    output logic [23:0] time_bcd,
    output logic        locked,
    output logic        err_code,
    output logic        err_range,
    output logic        err_step,
    output logic        err_stall,
    output logic [15:0] err_count
);

    typedef enum logic {SYNC, TRACK} state_t;

    localparam int GW = $clog2(MAX_GAP + 1);

    state_t        state_q, state_d;
    logic [41:0]   s_q;
    logic          s_vld;
    logic [23:0]   ref_q, ref_d, ref_inc, time_d, samp;
    logic [5:0]    bad_bus;
    logic [GW-1:0] gap_q, gap_d;
    logic          code_bad, range_bad, hr_ok;
    logic          e_code, e_range, e_step, e_stall;

    // bit 4 flags an illegal code, bits 3:0 carry the digit
    function automatic logic [4:0] seg_dec(input logic [6:0] seg);
        case (seg)
            7'b1111110: seg_dec = 5'h00;
            7'b0110000: seg_dec = 5'h01;
            7'b1101101: seg_dec = 5'h02;
            7'b1111001: seg_dec = 5'h03;
            7'b0110011: seg_dec = 5'h04;
            7'b1011011: seg_dec = 5'h05;
            7'b1011111: seg_dec = 5'h06;
            7'b1110000: seg_dec = 5'h07;
            7'b1111111: seg_dec = 5'h08;
            7'b1111011: seg_dec = 5'h09;
            default:    seg_dec = 5'h10;
        endcase
    endfunction

    for (genvar i = 0; i < 6; i++) begin : g_dec
        assign {bad_bus[i], samp[4*i +: 4]} = seg_dec(s_q[7*i +: 7]);
    end

    assign code_bad = |bad_bus;

    always_comb begin
        if (H12)
            hr_ok = (samp[23:20] == 4'd0 && samp[19:16] != 4'd0) ||
                    (samp[23:20] == 4'd1 && samp[19:16] <= 4'd2);
        else
            hr_ok = (samp[23:20] <= 4'd1) ||
                    (samp[23:20] == 4'd2 && samp[19:16] <= 4'd3);
    end

    assign range_bad = (samp[7:4] > 4'd5) || (samp[15:12] > 4'd5) || !hr_ok;

    // reference + 1 s with BCD carries
    always_comb begin
        ref_inc = ref_q;
        if (ref_q[3:0] != 4'd9) begin
            ref_inc[3:0] = ref_q[3:0] + 4'd1;
        end else begin
            ref_inc[3:0] = 4'd0;
            if (ref_q[7:4] != 4'd5) begin
                ref_inc[7:4] = ref_q[7:4] + 4'd1;
            end else begin
                ref_inc[7:4] = 4'd0;
                if (ref_q[11:8] != 4'd9) begin
                    ref_inc[11:8] = ref_q[11:8] + 4'd1;
                end else begin
                    ref_inc[11:8] = 4'd0;
                    if (ref_q[15:12] != 4'd5) begin
                        ref_inc[15:12] = ref_q[15:12] + 4'd1;
                    end else begin
                        ref_inc[15:12] = 4'd0;
                        if (H12 && ref_q[23:16] == 8'h12)
                            ref_inc[23:16] = 8'h01;
                        else if (!H12 && ref_q[23:16] == 8'h23)
                            ref_inc[23:16] = 8'h00;
                        else if (ref_q[19:16] == 4'd9)
                            ref_inc[23:16] = {ref_q[23:20] + 4'd1, 4'd0};
                        else
                            ref_inc[19:16] = ref_q[19:16] + 4'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        time_d  = time_bcd;
        gap_d   = gap_q;
        e_code  = 1'b0;
        e_range = 1'b0;
        e_step  = 1'b0;
        e_stall = 1'b0;
        if (s_vld) begin
            if (code_bad) begin
                e_code  = 1'b1;
                state_d = SYNC;
                gap_d   = '0;
            end else if (range_bad) begin
                e_range = 1'b1;
                state_d = SYNC;
                gap_d   = '0;
            end else if (state_q == SYNC || samp != ref_q) begin
                e_step  = (state_q == TRACK) && (samp != ref_inc);
                state_d = TRACK;
                ref_d   = samp;
                time_d  = samp;
                gap_d   = '0;
            end else if (gap_q == GW'(MAX_GAP - 1)) begin
                e_stall = 1'b1;
                gap_d   = '0;
            end else begin
                gap_d   = gap_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q       <= '0;
            s_vld     <= 1'b0;
            state_q   <= SYNC;
            ref_q     <= '0;
            time_bcd  <= '0;
            gap_q     <= '0;
            err_code  <= 1'b0;
            err_range <= 1'b0;
            err_step  <= 1'b0;
            err_stall <= 1'b0;
            err_count <= '0;
        end else begin
            s_q       <= {hm, hl, mm, ml, sm, sl};
            s_vld     <= 1'b1;
            state_q   <= state_d;
            ref_q     <= ref_d;
            time_bcd  <= time_d;
            gap_q     <= gap_d;
            err_code  <= e_code;
            err_range <= e_range;
            err_step  <= e_step;
            err_stall <= e_stall;
            if ((e_code | e_range | e_step | e_stall) && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end

    assign locked = (state_q == TRACK);

endmodule

// File: tb/tb_rtc_seg_monitor.sv
// Scoreboard bench for rtc_seg_monitor: stimulus queues expected outputs two
// edges ahead, a negedge monitor pops and compares them.
module tb_rtc_seg_monitor;

    localparam logic [3:0] E_NONE  = 4'b0000;
    localparam logic [3:0] E_CODE  = 4'b1000;
    localparam logic [3:0] E_RANGE = 4'b0100;
    localparam logic [3:0] E_STEP  = 4'b0010;
    localparam logic [3:0] E_STALL = 4'b0001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  sl = '0, sm = '0, ml = '0, mm = '0, hl = '0, hm = '0;

    logic [23:0] time24, time12;
    logic        lock24, lock12;
    logic        code24, range24, step24, stall24;
    logic        code12, range12, step12, stall12;
    logic [15:0] cnt24, cnt12;

    rtc_seg_monitor #(.H12(1'b0), .MAX_GAP(16)) dut24 (
        .clk(clk), .rst(rst), .sl(sl), .sm(sm), .ml(ml), .mm(mm), .hl(hl), .hm(hm),
        .time_bcd(time24), .locked(lock24), .err_code(code24), .err_range(range24),
        .err_step(step24), .err_stall(stall24), .err_count(cnt24)
    );

    rtc_seg_monitor #(.H12(1'b1), .MAX_GAP(16)) dut12 (
        .clk(clk), .rst(rst), .sl(sl), .sm(sm), .ml(ml), .mm(mm), .hl(hl), .hm(hm),
        .time_bcd(time12), .locked(lock12), .err_code(code12), .err_range(range12),
        .err_step(step12), .err_stall(stall12), .err_count(cnt12)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          sec;
        bit          sel;
        logic [23:0] t;
        logic        lk;
        logic [3:0]  e;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          section = 0;
    bit          sel = 1'b0;
    logic [15:0] exp_cnt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] dig2seg(input logic [3:0] d);
        case (d)
            4'd0: dig2seg = 7'b1111110;
            4'd1: dig2seg = 7'b0110000;
            4'd2: dig2seg = 7'b1101101;
            4'd3: dig2seg = 7'b1111001;
            4'd4: dig2seg = 7'b0110011;
            4'd5: dig2seg = 7'b1011011;
            4'd6: dig2seg = 7'b1011111;
            4'd7: dig2seg = 7'b1110000;
            4'd8: dig2seg = 7'b1111111;
            4'd9: dig2seg = 7'b1111011;
            default: dig2seg = 7'b0000000;
        endcase
    endfunction

    // seconds-of-day to {hm,hl,mm,ml,sm,sl}
    function automatic logic [23:0] to_bcd(input int s_in, input bit h12);
        int s, h, m, sc;
        s  = s_in % 86400;
        h  = s / 3600;
        m  = (s / 60) % 60;
        sc = s % 60;
        if (h12) h = (h % 12 == 0) ? 12 : h % 12;
        to_bcd = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    task automatic step(input logic [23:0] t, input bit bad_sl, input logic [23:0] et,
                        input bit elk, input logic [3:0] ee);
        exp_t r;
        @(negedge clk);
        rst = 1'b1;
        sl = bad_sl ? 7'b0000001 : dig2seg(t[3:0]);
        sm = dig2seg(t[7:4]);
        ml = dig2seg(t[11:8]);
        mm = dig2seg(t[15:12]);
        hl = dig2seg(t[19:16]);
        hm = dig2seg(t[23:20]);
        if (ee != E_NONE && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        r.due = cyc + 2;
        r.sec = section;
        r.sel = sel;
        r.t   = et;
        r.lk  = elk;
        r.e   = ee;
        r.cnt = exp_cnt;
        q.push_back(r);
    endtask

    task automatic check_zero();
        total++;
        if ({time24, lock24, code24, range24, step24, stall24, cnt24} !== 45'd0) begin
            bad++;
            $display("FAIL reset24 sec=%0d act t=%h lk=%b e=%b%b%b%b cnt=%h required all zero",
                     section, time24, lock24, code24, range24, step24, stall24, cnt24);
        end
        total++;
        if ({time12, lock12, code12, range12, step12, stall12, cnt12} !== 45'd0) begin
            bad++;
            $display("FAIL reset12 sec=%0d act t=%h lk=%b e=%b%b%b%b cnt=%h required all zero",
                     section, time12, lock12, code12, range12, step12, stall12, cnt12);
        end
    endtask

    // reset asserted between clock edges; outputs must clear at once
    task automatic do_reset();
        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain sec=%0d pending=%0d required 0", section, q.size());
        end
        q.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check_zero();
        repeat (2) @(negedge clk);
        exp_cnt = '0;
    endtask

    always @(negedge clk) begin
        exp_t        r;
        logic [44:0] act, req;
        while (q.size() > 0 && q[0].due < cyc) begin
            r = q.pop_front();
            total++;
            bad++;
            $display("FAIL missed sec=%0d due=%0d now=%0d", r.sec, r.due, cyc);
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            act = r.sel ? {time12, lock12, code12, range12, step12, stall12, cnt12}
                        : {time24, lock24, code24, range24, step24, stall24, cnt24};
            req = {r.t, r.lk, r.e, r.cnt};
            total++;
            if (act !== req) begin
                bad++;
                $display("FAIL out sec=%0d cyc=%0d act t=%h lk=%b e=%b cnt=%h required t=%h lk=%b e=%b cnt=%h",
                         r.sec, cyc, act[44:21], act[20], act[19:16], act[15:0],
                         r.t, r.lk, r.e, r.cnt);
            end
        end
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        // reset then lock at 00:00:00, then a slow walk (one step per 4 cycles)
        section = 1;
        sel = 1'b0;
        #12 check_zero();
        repeat (2) @(negedge clk);
        step(24'h000000, 0, 24'h000000, 1, E_NONE);
        for (int s = 1; s <= 65; s++)
            for (int k = 0; k < 4; k++)
                step(to_bcd(s, 0), 0, to_bcd(s, 0), 1, E_NONE);

        // fast walk across 20..23 h and the midnight wrap
        section = 2;
        do_reset();
        s0 = 19 * 3600 + 58 * 60;
        step(to_bcd(s0, 0), 0, to_bcd(s0, 0), 1, E_NONE);
        for (int s = s0 + 1; s <= 86400 + 120; s++)
            step(to_bcd(s, 0), 0, to_bcd(s, 0), 1, E_NONE);

        // 12 h: 11:59:59 -> 12:00:00 ... 12:59:59 -> 01:00:00, then 00:00:00
        section = 3;
        sel = 1'b1;
        do_reset();
        s0 = 11 * 3600 + 3599;
        step(to_bcd(s0, 1), 0, to_bcd(s0, 1), 1, E_NONE);
        for (int s = s0 + 1; s <= 13 * 3600; s++)
            step(to_bcd(s, 1), 0, to_bcd(s, 1), 1, E_NONE);
        step(24'h000000, 0, 24'h010000, 0, E_RANGE);
        step(24'h000000, 0, 24'h010000, 0, E_RANGE);

        // stall every 16 held cycles; code beats stall on the same cycle
        section = 4;
        sel = 1'b0;
        do_reset();
        step(24'h123456, 0, 24'h123456, 1, E_NONE);
        for (int i = 1; i < 48; i++)
            step(24'h123456, 0, 24'h123456, 1, (i % 16 == 0) ? E_STALL : E_NONE);
        step(24'h123456, 1, 24'h123456, 0, E_CODE);

        // bad code, relock, bad step
        section = 5;
        do_reset();
        step(24'h102030, 0, 24'h102030, 1, E_NONE);
        step(24'h102030, 1, 24'h102030, 0, E_CODE);
        step(24'h102040, 0, 24'h102040, 1, E_NONE);
        step(24'h102045, 0, 24'h102045, 1, E_STEP);

        // mid-run async reset, then drive err_count into saturation
        section = 6;
        do_reset();
        for (int n = 0; n < 70000; n++)
            step(24'h000000, 1, 24'h000000, 0, E_CODE);
        step(24'h000000, 0, 24'h000000, 1, E_NONE);

        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL final_drain pending=%0d required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
